// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the MIPS multi-cycle sequencer: opcode/funct encodings,
// ALU control codes and the sequencer state enum.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_NOR   = 6'd39;
    localparam logic [5:0] FN_SLT   = 6'd42;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_NOR  = 4'd12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/mips_instr_decode.sv
// Combinational opcode/funct decoder producing datapath selects, ALU code and
// instruction-class flags; unsupported encodings raise o_illegal.
module mips_instr_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic       o_reg_dst,
    output logic       o_alu_src,
    output logic       o_mem_to_reg,
    output logic [3:0] o_alu_ctrl,
    output logic       o_is_mem,
    output logic       o_is_store,
    output logic       o_illegal
);

    always_comb begin
        o_reg_dst    = 1'b0;
        o_alu_src    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_alu_ctrl   = ALU_ADD;
        o_is_mem     = 1'b0;
        o_is_store   = 1'b0;
        o_illegal    = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_reg_dst = 1'b1;
                case (i_funct)
                    FN_ADD:  o_alu_ctrl = ALU_ADD;
                    FN_SUB:  o_alu_ctrl = ALU_SUB;
                    FN_AND:  o_alu_ctrl = ALU_AND;
                    FN_OR:   o_alu_ctrl = ALU_OR;
                    FN_NOR:  o_alu_ctrl = ALU_NOR;
                    FN_SLT:  o_alu_ctrl = ALU_SLT;
                    default: begin
                        o_reg_dst = 1'b0;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                o_alu_src    = 1'b1;
                o_mem_to_reg = 1'b1;
                o_is_mem     = 1'b1;
            end
            OP_SW: begin
                o_alu_src  = 1'b1;
                o_is_mem   = 1'b1;
                o_is_store = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_instr_sequencer.sv
// Handshaked multi-cycle MIPS control sequencer (IDLE/DECODE/EXEC/MEM/WB/DONE).
// Optional `MIPS_SEQ_PERF_EN adds retired/illegal instruction counters.
module mips_instr_sequencer
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr_word,
    output logic [31:0] instr_q,
    output logic        reg_dst,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic [3:0]  alu_ctrl,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        done,
    output logic        err
`ifdef MIPS_SEQ_PERF_EN
    ,
    output logic [31:0] perf_instr_cnt,
    output logic [31:0] perf_err_cnt
`endif
);

    seq_state_t  r_state;
    seq_state_t  w_state_next;

    logic [31:0] r_instr_q;
    logic        r_ready;
    logic        r_reg_dst;
    logic        r_alu_src;
    logic        r_mem_to_reg;
    logic [3:0]  r_alu_ctrl;
    logic        r_is_mem;
    logic        r_is_store;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_done;
    logic        r_err;

    logic        w_reg_dst;
    logic        w_alu_src;
    logic        w_mem_to_reg;
    logic [3:0]  w_alu_ctrl;
    logic        w_is_mem;
    logic        w_is_store;
    logic        w_illegal;
    logic        w_accept;

    mips_instr_decode u_decode (
        .i_opcode     (r_instr_q[31:26]),
        .i_funct      (r_instr_q[5:0]),
        .o_reg_dst    (w_reg_dst),
        .o_alu_src    (w_alu_src),
        .o_mem_to_reg (w_mem_to_reg),
        .o_alu_ctrl   (w_alu_ctrl),
        .o_is_mem     (w_is_mem),
        .o_is_store   (w_is_store),
        .o_illegal    (w_illegal)
    );

    // r_ready is only ever high in IDLE, so it alone qualifies the handshake
    assign w_accept = r_ready && instr_valid;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_next = S_DECODE;
            S_DECODE: w_state_next = w_illegal ? S_DONE : S_EXEC;
            S_EXEC:   w_state_next = r_is_mem ? S_MEM : S_WB;
            S_MEM:    w_state_next = r_is_store ? S_DONE : S_WB;
            S_WB:     w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each strobe lines up
    // exactly with the cycle its state is occupied.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_instr_q    <= '0;
            r_ready      <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_alu_src    <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_ctrl   <= ALU_ADD;
            r_is_mem     <= 1'b0;
            r_is_store   <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_ready     <= (w_state_next == S_IDLE);
            r_reg_write <= (w_state_next == S_WB);
            r_mem_read  <= (w_state_next == S_MEM) && !r_is_store;
            r_mem_write <= (w_state_next == S_MEM) && r_is_store;
            r_done      <= (w_state_next == S_DONE);
            r_err       <= (w_state_next == S_DONE) && (r_state == S_DECODE);
            if (w_accept) r_instr_q <= instr_word;
            if (r_state == S_DECODE) begin
                r_reg_dst    <= w_reg_dst;
                r_alu_src    <= w_alu_src;
                r_mem_to_reg <= w_mem_to_reg;
                r_alu_ctrl   <= w_alu_ctrl;
                r_is_mem     <= w_is_mem;
                r_is_store   <= w_is_store;
            end
        end
    end

`ifdef MIPS_SEQ_PERF_EN
    logic [31:0] r_perf_instr_cnt;
    logic [31:0] r_perf_err_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_instr_cnt <= '0;
            r_perf_err_cnt   <= '0;
        end else if (r_done) begin
            if (r_err) r_perf_err_cnt   <= r_perf_err_cnt + 32'd1;
            else       r_perf_instr_cnt <= r_perf_instr_cnt + 32'd1;
        end
    end

    assign perf_instr_cnt = r_perf_instr_cnt;
    assign perf_err_cnt   = r_perf_err_cnt;
`endif

    assign instr_ready = r_ready;
    assign instr_q     = r_instr_q;
    assign reg_dst     = r_reg_dst;
    assign alu_src     = r_alu_src;
    assign mem_to_reg  = r_mem_to_reg;
    assign alu_ctrl    = r_alu_ctrl;
    assign reg_write   = r_reg_write;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign done        = r_done;
    assign err         = r_err;

endmodule

// File: tb/tb_mips_instr_sequencer.sv
// Self-checking bench for mips_instr_sequencer: directed and randomized
// instructions checked cycle-by-cycle against a timing/decode reference model.
module tb_mips_instr_sequencer;

    localparam int KR   = 0;
    localparam int KLW  = 1;
    localparam int KSW  = 2;
    localparam int KILL = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_word;
    logic [31:0] instr_q;
    logic        reg_dst;
    logic        alu_src;
    logic        mem_to_reg;
    logic [3:0]  alu_ctrl;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        done;
    logic        err;
`ifdef MIPS_SEQ_PERF_EN
    logic [31:0] perf_instr_cnt;
    logic [31:0] perf_err_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic        tr_rw [1:8];
    logic        tr_mr [1:8];
    logic        tr_mw [1:8];
    logic        tr_done [1:8];
    logic        tr_err [1:8];
    logic        tr_ready [1:8];
    logic        tr_rd [1:8];
    logic        tr_as [1:8];
    logic        tr_mtr [1:8];
    logic [3:0]  tr_alu [1:8];
    logic [31:0] tr_q [1:8];

    logic [5:0]  legal_fn [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};

    always #5 clk = ~clk;

    mips_instr_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_word  (instr_word),
        .instr_q     (instr_q),
        .reg_dst     (reg_dst),
        .alu_src     (alu_src),
        .mem_to_reg  (mem_to_reg),
        .alu_ctrl    (alu_ctrl),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .done        (done),
        .err         (err)
`ifdef MIPS_SEQ_PERF_EN
        ,
        .perf_instr_cnt (perf_instr_cnt),
        .perf_err_cnt   (perf_err_cnt)
`endif
    );

    // ---------------- reference model ----------------
    function automatic int kind_of(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        if (op == 6'd0)  return (fn inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42}) ? KR : KILL;
        if (op == 6'd35) return KLW;
        if (op == 6'd43) return KSW;
        return KILL;
    endfunction

    function automatic logic [3:0] alu_of(input logic [31:0] w);
        if (kind_of(w) != KR) return 4'd2;
        case (w[5:0])
            6'd32:   return 4'd2;
            6'd34:   return 4'd6;
            6'd36:   return 4'd0;
            6'd37:   return 4'd1;
            6'd39:   return 4'd12;
            default: return 4'd7;
        endcase
    endfunction

    // cycles after the handshake edge at which done pulses
    function automatic int lat_of(input int kind);
        case (kind)
            KR:      return 4;
            KLW:     return 5;
            KSW:     return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int rw_cycle(input int kind);
        return (kind == KR) ? 3 : (kind == KLW) ? 4 : 0;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [5:0] op;
        logic [5:0] fn;
        case ($urandom_range(0, 3))
            0: return {6'd0, 20'($urandom), legal_fn[$urandom_range(0, 5)]};
            1: return {6'd35, 26'($urandom)};
            2: return {6'd43, 26'($urandom)};
            default: begin
                if ($urandom_range(0, 1) == 1) begin
                    op = 6'($urandom_range(1, 63));
                    if (op == 6'd35 || op == 6'd43) op = 6'd2;
                    return {op, 26'($urandom)};
                end
                do fn = 6'($urandom); while (fn inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42});
                return {6'd0, 20'($urandom), fn};
            end
        endcase
    endfunction

    // ---------------- stimulus / capture ----------------
    // Called at a negedge; performs the handshake then records k_cycles cycles,
    // toggling instr_valid with junk words while the sequencer is busy.
    task automatic run_instr(input logic [31:0] w, input int k_cycles);
        int waited;
        waited = 0;
        while (instr_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake_wait ready=%b required 1", instr_ready);
        end
        instr_valid = 1'b1;
        instr_word  = w;
        @(posedge clk);
        for (int k = 1; k <= k_cycles; k++) begin
            @(negedge clk);
            tr_rw[k]    = reg_write;
            tr_mr[k]    = mem_read;
            tr_mw[k]    = mem_write;
            tr_done[k]  = done;
            tr_err[k]   = err;
            tr_ready[k] = instr_ready;
            tr_rd[k]    = reg_dst;
            tr_as[k]    = alu_src;
            tr_mtr[k]   = mem_to_reg;
            tr_alu[k]   = alu_ctrl;
            tr_q[k]     = instr_q;
            if (k < k_cycles) begin
                instr_valid = 1'($urandom_range(0, 1));
                instr_word  = $urandom;
            end else begin
                instr_valid = 1'b0;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        instr_valid = 1'b1;
        instr_word  = 32'h0022_1820;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({reg_write, mem_read, mem_write, done, err} !== 5'b0) begin
                errors++;
                $display("FAIL reset_strobes rw/mr/mw/done/err=%b required 00000",
                         {reg_write, mem_read, mem_write, done, err});
            end
            checks++;
            if (instr_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready got=%b required 0", instr_ready);
            end
            checks++;
            if ({reg_dst, alu_src, mem_to_reg, alu_ctrl} !== 7'b000_0010 || instr_q !== 32'h0) begin
                errors++;
                $display("FAIL reset_selects sel=%b alu=%0d q=%h required 000 alu=2 q=0",
                         {reg_dst, alu_src, mem_to_reg}, alu_ctrl, instr_q);
            end
        end
        rst = 1'b1;
        instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b required 1", instr_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] dir [5] = '{32'h0022_1820, 32'h8C05_0004, 32'hAC05_0008,
                                 32'h1000_0000, 32'h0022_1800};
        int kind;
        int lat;
        logic exp_rw;
        logic exp_mr;
        logic exp_mw;
        for (int i = 0; i < 5; i++) begin
            kind = kind_of(dir[i]);
            lat  = lat_of(kind);
            run_instr(dir[i], lat + 1);
            for (int k = 1; k <= lat + 1; k++) begin
                exp_rw = (k == rw_cycle(kind));
                exp_mr = (kind == KLW) && (k == 3);
                exp_mw = (kind == KSW) && (k == 3);
                checks++;
                if ({tr_rw[k], tr_mr[k], tr_mw[k]} !== {exp_rw, exp_mr, exp_mw}) begin
                    errors++;
                    $display("FAIL dir%0d_strobes cyc=N+%0d rw/mr/mw=%b%b%b required %b%b%b",
                             i, k, tr_rw[k], tr_mr[k], tr_mw[k], exp_rw, exp_mr, exp_mw);
                end
                checks++;
                if ({tr_done[k], tr_err[k], tr_ready[k]} !==
                    {k == lat, (k == lat) && (kind == KILL), k == lat + 1}) begin
                    errors++;
                    $display("FAIL dir%0d_ctrl cyc=N+%0d done/err/ready=%b%b%b required %b%b%b",
                             i, k, tr_done[k], tr_err[k], tr_ready[k],
                             k == lat, (k == lat) && (kind == KILL), k == lat + 1);
                end
                checks++;
                if (tr_q[k] !== dir[i]) begin
                    errors++;
                    $display("FAIL dir%0d_instr_q cyc=N+%0d got=%h required %h", i, k, tr_q[k], dir[i]);
                end
                if (kind != KILL && k >= 2) begin
                    checks++;
                    if ({tr_rd[k], tr_as[k], tr_mtr[k], tr_alu[k]} !==
                        {kind == KR, kind != KR, kind == KLW, alu_of(dir[i])}) begin
                        errors++;
                        $display("FAIL dir%0d_selects cyc=N+%0d rd/as/mtr=%b%b%b alu=%0d required %b%b%b alu=%0d",
                                 i, k, tr_rd[k], tr_as[k], tr_mtr[k], tr_alu[k],
                                 kind == KR, kind != KR, kind == KLW, alu_of(dir[i]));
                    end
                end
            end
        end
    endtask

    task automatic test_perf();
`ifdef MIPS_SEQ_PERF_EN
        checks++;
        if (perf_err_cnt !== 32'd2 || perf_instr_cnt !== 32'd3) begin
            errors++;
            $display("FAIL perf_counts instr=%0d err=%0d required instr=3 err=2",
                     perf_instr_cnt, perf_err_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        int kind;
        int lat;
        int n_rw;
        int n_mr;
        int n_mw;
        int n_done;
        int done_at;
        int overlap;
        for (int i = 0; i < 60; i++) begin
            w    = rand_word();
            kind = kind_of(w);
            lat  = lat_of(kind);
            run_instr(w, lat + 1);
            n_rw = 0; n_mr = 0; n_mw = 0; n_done = 0; done_at = 0; overlap = 0;
            for (int k = 1; k <= lat + 1; k++) begin
                n_rw += int'(tr_rw[k]);
                n_mr += int'(tr_mr[k]);
                n_mw += int'(tr_mw[k]);
                if (tr_done[k] === 1'b1) begin n_done++; done_at = k; end
                if (int'(tr_rw[k]) + int'(tr_mr[k]) + int'(tr_mw[k]) > 1) overlap++;
            end
            checks++;
            if (n_done != 1 || done_at != lat) begin
                errors++;
                $display("FAIL b2b%0d_done word=%h pulses=%0d at=N+%0d required 1 at N+%0d",
                         i, w, n_done, done_at, lat);
            end
            checks++;
            if (tr_err[lat] !== (kind == KILL)) begin
                errors++;
                $display("FAIL b2b%0d_err word=%h got=%b required %b", i, w, tr_err[lat], kind == KILL);
            end
            checks++;
            if (n_rw != ((kind == KR || kind == KLW) ? 1 : 0) || n_mr != ((kind == KLW) ? 1 : 0) ||
                n_mw != ((kind == KSW) ? 1 : 0) || overlap != 0) begin
                errors++;
                $display("FAIL b2b%0d_strobes word=%h rw=%0d mr=%0d mw=%0d overlap=%0d kind=%0d",
                         i, w, n_rw, n_mr, n_mw, overlap, kind);
            end
            if (kind != KILL) begin
                checks++;
                if (tr_alu[lat] !== alu_of(w)) begin
                    errors++;
                    $display("FAIL b2b%0d_alu word=%h got=%0d required %0d", i, w, tr_alu[lat], alu_of(w));
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        run_instr(32'h8C05_0004, 2);
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1) begin
            errors++;
            $display("FAIL abort_mem_read got=%b required 1", mem_read);
        end
        rst = 1'b0;
        instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({reg_write, mem_read, mem_write, done, instr_ready} !== 5'b0) begin
            errors++;
            $display("FAIL abort_reset_cycle rw/mr/mw/done/ready=%b required 00000",
                     {reg_write, mem_read, mem_write, done, instr_ready});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({reg_write, done, instr_ready} !== 3'b001) begin
            errors++;
            $display("FAIL abort_release rw/done/ready=%b required 001", {reg_write, done, instr_ready});
        end
        run_instr(32'hAC05_0008, 5);
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if ({tr_rw[k], tr_mr[k], tr_mw[k], tr_done[k]} !== {1'b0, 1'b0, k == 3, k == 4}) begin
                errors++;
                $display("FAIL abort_sw cyc=N+%0d rw/mr/mw/done=%b%b%b%b required 00%b%b",
                         k, tr_rw[k], tr_mr[k], tr_mw[k], tr_done[k], k == 3, k == 4);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_perf();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
